prefetch_ifu: RTL

Parametrised prefetching instruction-fetch unit that replaces the single-request fetch stage in front of decode. It keeps up to `MAX_OUTSTANDING` pipelined requests in flight to instruction memory, buffers returned instructions with their PCs in a `DEPTH`-entry queue, and presents them to decode through a valid/ready handshake. A redirect from branch/jump resolution flushes the queue and discards in-flight responses.

---
 rtl/prefetch_ifu.sv | 128 ++++++++++++
 1 files changed

// File: rtl/prefetch_ifu.sv
`default_nettype none
// ============================================================================
// Module   : prefetch_ifu
// Brief    : Prefetching instruction-fetch unit with pipelined memory requests
//            and an instruction/PC queue in front of decode.
// Revision : 1.0
// ============================================================================
module prefetch_ifu #(
    parameter int             XLEN            = 64,
    parameter logic [XLEN-1:0] RESET_PC       = '0,
    parameter int             DEPTH           = 4,
    parameter int             MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            instr_mem_req_o,
    output logic [XLEN-1:0] instr_mem_addr_o,
    input  logic            instr_mem_gnt_i,
    input  logic            instr_mem_rvalid_i,
    input  logic [31:0]     instr_mem_rdata_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            instr_valid_o,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] instr_pc_o,
    input  logic            instr_ready_i
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int c_OCC_W = $clog2(DEPTH + 1);
    localparam int c_SUM_W = c_OCC_W + c_CNT_W + 1;
    localparam logic [c_CNT_W-1:0] c_MAX_OUT = c_CNT_W'(MAX_OUTSTANDING);
    localparam logic [c_SUM_W-1:0] c_DEPTH   = c_SUM_W'(DEPTH);
    localparam logic [XLEN-1:0]    c_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0]    c_ALIGN   = ~XLEN'(3);

    logic [XLEN-1:0]    r_fetch_pc;
    logic [XLEN-1:0]    r_rsp_pc;
    logic [c_CNT_W-1:0] r_out_cnt;
    logic [c_CNT_W-1:0] r_drop_cnt;
    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic [c_OCC_W-1:0] r_occ;
    logic [31:0]        r_q_instr [DEPTH];
    logic [XLEN-1:0]    r_q_pc    [DEPTH];

    logic               w_req;
    logic               w_gnt;
    logic               w_rsp;
    logic               w_drop;
    logic               w_push;
    logic               w_valid;
    logic               w_pop;
    logic [c_SUM_W-1:0] w_used;
    logic [c_CNT_W-1:0] w_out_after_rsp;
    logic [XLEN-1:0]    w_redirect_pc;
    logic [c_PTR_W-1:0] w_wr_idx;
    logic [c_PTR_W-1:0] w_rd_idx;

    // Credits count queued entries plus live (non-dropped) in-flight responses,
    // so every accepted response is guaranteed a queue slot.
    assign w_used          = c_SUM_W'(r_occ) + c_SUM_W'(r_out_cnt - r_drop_cnt);
    assign w_req           = reset && !redirect_i && (r_out_cnt < c_MAX_OUT) && (w_used < c_DEPTH);
    assign w_gnt           = w_req && instr_mem_gnt_i;
    assign w_rsp           = instr_mem_rvalid_i && (r_out_cnt != '0);
    assign w_drop          = w_rsp && (r_drop_cnt != '0);
    assign w_push          = w_rsp && !w_drop;
    assign w_valid         = (r_occ != '0);
    assign w_pop           = w_valid && instr_ready_i;
    assign w_out_after_rsp = r_out_cnt - c_CNT_W'(w_rsp);
    assign w_redirect_pc   = redirect_pc_i & c_ALIGN;
    assign w_wr_idx        = r_wr_ptr[c_PTR_W-1:0];
    assign w_rd_idx        = r_rd_ptr[c_PTR_W-1:0];

    assign instr_mem_req_o  = w_req;
    assign instr_mem_addr_o = r_fetch_pc;
    assign instr_valid_o    = w_valid;
    assign instr_o          = w_valid ? r_q_instr[w_rd_idx] : 32'h0;
    assign instr_pc_o       = w_valid ? r_q_pc[w_rd_idx]    : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
        end else if (redirect_i) begin
            // Everything still in flight after this edge belongs to the old path.
            r_fetch_pc <= w_redirect_pc;
            r_rsp_pc   <= w_redirect_pc;
            r_out_cnt  <= w_out_after_rsp;
            r_drop_cnt <= w_out_after_rsp;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
        end else begin
            if (w_gnt) begin
                r_fetch_pc <= r_fetch_pc + c_STEP;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + c_STEP;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
            r_out_cnt <= w_out_after_rsp + c_CNT_W'(w_gnt);
            r_occ     <= r_occ + c_OCC_W'(w_push) - c_OCC_W'(w_pop);
        end
    end

    // Queue storage needs no reset: the head is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (w_push && !redirect_i) begin
            r_q_instr[w_wr_idx] <= instr_mem_rdata_i;
            r_q_pc[w_wr_idx]    <= r_rsp_pc;
        end
    end

endmodule
`default_nettype wire
